// File: rtl/data_flow_decoder.sv
// rtl/data_flow_decoder.sv - receive-side decoder for the 2-bit data_flow code
//
// Purpose:
//   Accepts code symbols {q1,q0} (q1=a|b, q0=a|(~b&c)) over a valid/ready
//   handshake and buffers them in a small FIFO. The FIFO head is decoded back
//   to the (a,b,c) pattern plus a mask of the bits the code actually
//   determines. A saturating occurrence counter is kept per code value.
//
// Ports:
//   clk         in   1                rising-edge clock
//   rst_n       in   1                asynchronous active-low reset
//   in_valid    in   1                in_code valid this cycle
//   in_ready    out  1                FIFO not full
//   in_code     in   2                code symbol {q1,q0}
//   out_valid   out  1                FIFO head valid
//   out_ready   in   1                consumer takes the head this cycle
//   out_abc     out  3                decoded {a,b,c}; unknown bits are 0
//   out_known   out  3                1 = matching out_abc bit is determined
//   out_ambig   out  1                out_known != 3'b111
//   fifo_level  out  $clog2(DEPTH)+1  entries held
//   clr_cnt     in   1                synchronous clear of all counters
//   cnt_sel     in   2                code value whose counter drives cnt_val
//   cnt_val     out  CNT_W            occurrence count for code cnt_sel

module data_flow_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_abc,
  output logic [2:0]                 out_known,
  output logic                       out_ambig,
  output logic [$clog2(DEPTH):0]     fifo_level,
  input  logic                       clr_cnt,
  input  logic [1:0]                 cnt_sel,
  output logic [CNT_W-1:0]           cnt_val
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Raw codes are stored; decoding happens on the head so the storage
  // stays two bits wide.
  logic [1:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] cnt [4];

  logic push;
  logic pop;
  logic [1:0] head;

  assign in_ready   = (level != LW'(DEPTH));
  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head       = mem[rd_ptr];
  assign cnt_val    = cnt[cnt_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (push && (cnt[in_code] != '1)) begin
      cnt[in_code] <= cnt[in_code] + 1'b1;
    end
  end

  // Code 10 leaves c free; code 11 leaves b and c free.
  always_comb begin
    out_abc   = 3'b000;
    out_known = 3'b000;
    if (out_valid) begin
      case (head)
        2'b00:   begin out_abc = 3'b000; out_known = 3'b111; end
        2'b01:   begin out_abc = 3'b001; out_known = 3'b111; end
        2'b10:   begin out_abc = 3'b010; out_known = 3'b110; end
        default: begin out_abc = 3'b100; out_known = 3'b100; end
      endcase
    end
    out_ambig = out_valid && (out_known != 3'b111);
  end

endmodule

// File: tb/tb_data_flow_decoder.sv
// tb/tb_data_flow_decoder.sv - randomized self-checking bench for data_flow_decoder

module tb_data_flow_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_abc;
  logic [2:0]       out_known;
  logic             out_ambig;
  logic [2:0]       fifo_level;
  logic             clr_cnt;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_val;

  int checks = 0;
  int errors = 0;

  logic [1:0] mq [$];
  int         mcnt [4];

  data_flow_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_abc(out_abc), .out_known(out_known), .out_ambig(out_ambig),
    .fifo_level(fifo_level),
    .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode by brute force: every (a,b,c) that encodes to the code; a bit is
  // known when all candidates agree on it.
  function automatic void ref_decode(input logic [1:0] code,
                                     output logic [2:0] abc, output logic [2:0] known);
    logic [2:0] all1;
    logic [2:0] any1;
    logic [2:0] p;
    logic [1:0] q;
    all1 = 3'b111;
    any1 = 3'b000;
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      q = {p[2] | p[1], p[2] | (~p[1] & p[0])};
      if (q == code) begin
        all1 &= p;
        any1 |= p;
      end
    end
    abc   = all1;
    known = all1 | ~any1;
  endfunction

  // Entered just after a falling edge; drives inputs, checks outputs against
  // the model, advances the model across the coming rising edge.
  task automatic step(input logic v, input logic [1:0] c, input logic ordy,
                      input logic clr, input logic [1:0] sel);
    logic [2:0] eabc;
    logic [2:0] eknown;
    bit acc;
    bit pp;
    in_valid = v; in_code = c; out_ready = ordy; clr_cnt = clr; cnt_sel = sel;
    #1;
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("cnt_val", 32'(cnt_val), 32'(mcnt[sel]));
    if (mq.size() != 0) begin
      ref_decode(mq[0], eabc, eknown);
      check("out_abc", 32'(out_abc), 32'(eabc));
      check("out_known", 32'(out_known), 32'(eknown));
      check("out_ambig", 32'(out_ambig), 32'(eknown != 3'b111));
    end
    acc = v && (mq.size() != DEPTH);
    pp  = ordy && (mq.size() != 0);
    if (pp)  void'(mq.pop_front());
    if (acc) mq.push_back(c);
    if (clr) begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else if (acc && mcnt[c] < CMAX) begin
      mcnt[c]++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = 2'b00; out_ready = 1'b0;
    clr_cnt = 1'b0; cnt_sel = 2'b00;
    model_reset();
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst level", 32'(fifo_level), 0);
    check("rst abc", 32'(out_abc), 0);
    check("rst known", 32'(out_known), 0);
    check("rst ambig", 32'(out_ambig), 0);
    check("rst cnt", 32'(cnt_val), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All four codes streamed through with the consumer always ready.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1, 1'b0, 2'(i));
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Fill to full with the consumer stalled; the fifth symbol waits.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(3 - i), 1'b0, 1'b0, 2'b01);
    #1;
    check("full level", 32'(fifo_level), 4);
    check("full in_ready", 32'(in_ready), 0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 2'b01);
    step(1'b1, 2'b01, 1'b1, 1'b0, 2'b01);
    step(1'b1, 2'b01, 1'b0, 1'b0, 2'b01);
    repeat (5) step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Level 2 with simultaneous push/pop across the pointer wrap.
    step(1'b1, 2'b10, 1'b0, 1'b0, 2'b10);
    step(1'b1, 2'b11, 1'b0, 1'b0, 2'b10);
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i), 1'b1, 1'b0, 2'b10);
    #1;
    check("pp level", 32'(fifo_level), 2);
    repeat (3) step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Saturation of the code-10 counter, then clear against an accept.
    step(1'b0, 2'b00, 1'b1, 1'b1, 2'b10);
    repeat (9) step(1'b1, 2'b10, 1'b1, 1'b0, 2'b10);
    #1;
    check("sat cnt", 32'(cnt_val), 7);
    step(1'b1, 2'b10, 1'b1, 1'b1, 2'b10);
    #1;
    check("clr cnt", 32'(cnt_val), 0);
    repeat (2) step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 1'b0, 1'b0, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 32'(out_valid), 0);
    check("mid rst level", 32'(fifo_level), 0);
    check("mid rst cnt", 32'(cnt_val), 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post rst in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0),
           2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
